trigger_handling_v2: RTL and testbench
======================================

Name: trigger_handling_v2

Overview:
Per-source trigger alignment for the ATRI L4→T1 path. Each of NUM_L4 level triggers is delayed by a programmable number of blocks (1 block = 2 clk_i cycles). The delayed triggers are merged into a single T1 pulse. Alongside each T1 the block emits the block offset the readout must step back from the current block counter, so that every source requests the same absolute block regardless of its delay or pretrigger.

Parameters:
NUM_L4, 4, number of L4 trigger sources (shared SCAL_NUM_L4)
PRETRG_BITS, 4, width of each per-source pretrigger field, in blocks
DELAY_BITS, 4, width of each per-source delay field, in blocks
BASE_OFFSET, 8, fixed block offset of the trigger path (shared constant)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
pretrigger_vector_i  in  PRETRG_BITS*NUM_L4  source i pretrigger at [PRETRG_BITS*i +: PRETRG_BITS]
delay_vector_i  in  DELAY_BITS*NUM_L4  source i delay at [DELAY_BITS*i +: DELAY_BITS]
l4_i  in  NUM_L4  level L4 triggers, one bit per source
T1_mask_i  in  1  when high, suppresses T1_o
l4_matched_o  out  NUM_L4  delayed copies of l4_i
T1_o  out  1  one-cycle T1 request pulse
T1_scaler_o  out  1  one-cycle pulse per T1 candidate, for scalers
T1_offset_o  out  9  block offset qualifying the T1

Behaviour:
- Delay line:
  - Bit i of l4_i, sampled at clock edge N, appears on l4_matched_o[i] at edge N + 2*delay_i + 2.
  - The fixed 2-cycle (1 block) internal latency applies even when delay = 0.
  - Pulse width and pattern are preserved exactly, including overlapping or back-to-back pulses.
- Implementation: per-source shift register of depth 2*(2^DELAY_BITS-1)+2 with a tap selected by delay_i. Delay/pretrigger inputs are quasi-static; a change takes effect on the next cycle and may glitch in-flight triggers.
- Candidate detection: a source qualifies in a cycle when its delayed bit is about to rise (0→1 on the registered l4_matched_o).
  - T1_o, T1_scaler_o, T1_offset_o and the rising l4_matched_o edge all update on the same clock edge.
- T1_scaler_o: pulses for 1 cycle whenever any source qualifies, regardless of T1_mask_i.
- T1_o: equals T1_scaler_o AND NOT T1_mask_i.
- T1_offset_o: loaded when any source qualifies, with BASE_OFFSET + pretrigger_k + 1, where k is the lowest-index qualifying source. Arithmetic is modulo 512. The value is held between T1s.
- Required invariant: (block counter at matched rise) − T1_offset_o = (block counter at l4 rise) − BASE_OFFSET − pretrigger_i + delay_i, for the block counter incrementing every 2nd cycle.
- Simultaneous qualifications: only one T1 is issued, and the offset follows the lowest index. Higher-index sources still show their l4_matched_o edge.
- A level held high produces exactly one T1; a new T1 requires the delayed bit to drop and rise again.
- Reset state:
  - Shift registers, l4_matched_o, T1_o and T1_scaler_o = 0; T1_offset_o = 0.
  - Triggers in flight are discarded.
  - l4_i already high at reset release counts as a rising edge at the first sampled cycle.

Decomposition:
- Shared package/header (trigger_defs): SCAL_NUM_L4, PRETRG_BITS, DELAY_BITS, BASE_OFFSET, per-source default TRIG_*_PRETRIGGER and TRIG_*_DELAY, and the source index map (RF0=0, RF1=1, CPU=2, CAL=3).
- One sub-module, trigger_delay_line: a single-bit programmable block delay, instantiated NUM_L4 times. Merge, priority and offset logic stay in the top.

Test Plan:
1. Single source: delay0=3, pre0=2; l4_i=0001 sampled at edge N → l4_matched_o[0] rises at N+8; T1_o and T1_scaler_o pulse 1 cycle there; T1_offset_o=11. The block-counter invariant holds.
2. Two sources with different delays: delay0=3, delay2=0, pre2=1; l4_i=0101 for 3 cycles, then 0001 for 33 cycles, then 0 → matched[2] rises at N+2 with offset 10; matched[0] rises at N+8 with offset 11; matched[0] stays high 36 cycles; exactly 2 T1 pulses. The invariant holds for both sources.
3. Mask: T1_mask_i=1 during scenario 1 → T1_o stays 0, T1_scaler_o still pulses, offset still 11.
4. Collision: delay1=delay3=2, pre1=5, pre3=0; l4_i=1010 → single T1 at N+6 with offset 14; matched[1] and matched[3] both rise.
5. Reset mid-flight: l4_i[0] pulse, then rst_i 1 cycle before emergence → no matched edge, no T1; all outputs 0 after reset.
6. Extremes: delay=15, pre=15 → latency 32 cycles, offset 24; repeat near a 9-bit block-counter wrap; the invariant holds modulo 512.

Source files
------------

// File: rtl/trigger_handling_v2_pkg.sv
// Shared trigger-path definitions: source count, field widths, the fixed
// path offset, per-source defaults and the source index map.
package trigger_handling_v2_pkg;

  localparam int SCAL_NUM_L4  = 4;
  localparam int PRETRG_BITS  = 4;
  localparam int DELAY_BITS   = 4;
  localparam int BASE_OFFSET  = 8;
  localparam int OFFSET_BITS  = 9;

  // Source index map into the L4 vectors
  typedef enum logic [1:0] {
    SRC_RF0 = 2'd0,
    SRC_RF1 = 2'd1,
    SRC_CPU = 2'd2,
    SRC_CAL = 2'd3
  } trig_src_e;

  // Power-on defaults for each source, in blocks
  localparam logic [PRETRG_BITS-1:0] TRIG_RF0_PRETRIGGER = 4'd2;
  localparam logic [PRETRG_BITS-1:0] TRIG_RF1_PRETRIGGER = 4'd2;
  localparam logic [PRETRG_BITS-1:0] TRIG_CPU_PRETRIGGER = 4'd0;
  localparam logic [PRETRG_BITS-1:0] TRIG_CAL_PRETRIGGER = 4'd0;
  localparam logic [DELAY_BITS-1:0]  TRIG_RF0_DELAY      = 4'd0;
  localparam logic [DELAY_BITS-1:0]  TRIG_RF1_DELAY      = 4'd0;
  localparam logic [DELAY_BITS-1:0]  TRIG_CPU_DELAY      = 4'd0;
  localparam logic [DELAY_BITS-1:0]  TRIG_CAL_DELAY      = 4'd0;

  // Block offset the readout steps back for a source with pretrigger pre.
  // The +1 accounts for the fixed one-block latency of the delay line.
  function automatic logic [OFFSET_BITS-1:0] calc_offset(input logic [OFFSET_BITS-1:0] pre);
    return OFFSET_BITS'(BASE_OFFSET) + pre + OFFSET_BITS'(1);
  endfunction

endpackage

// File: rtl/trigger_handling_v2_delay_line.sv
// Single-bit programmable block delay: input sampled at edge N appears on
// matched_o at edge N + 2*delay_i + 2. next_o is the value matched_o will
// take at the coming edge, so the merge logic can act on the same edge.
module trigger_handling_v2_delay_line #(
  parameter int DELAY_BITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DELAY_BITS-1:0] delay_i,
  input  logic                  l4_i,
  output logic                  next_o,
  output logic                  matched_o
);

  // 2*(2^DELAY_BITS-1)+2 stages, which is exactly 2^(DELAY_BITS+1)
  localparam int TAP_W = DELAY_BITS + 1;
  localparam int DEPTH = 1 << TAP_W;

  logic [DEPTH-1:0] sr;
  logic [TAP_W-1:0] tap_idx;

  // Odd tap: 2*delay+1 stages plus the output register gives 2*delay+2
  assign tap_idx = {delay_i, 1'b1};
  assign next_o  = sr[tap_idx];

  // Shift the level trigger along the delay chain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr <= '0;
    end else begin
      sr <= {sr[DEPTH-2:0], l4_i};
    end
  end

  // Register the selected tap as the delayed trigger
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      matched_o <= 1'b0;
    end else begin
      matched_o <= next_o;
    end
  end

endmodule

// File: rtl/trigger_handling_v2.sv
// Per-source L4 trigger alignment and merge into a single T1 pulse with the
// block offset that makes every source request the same absolute block.
module trigger_handling_v2
  import trigger_handling_v2_pkg::*;
#(
  parameter int NUM_L4   = SCAL_NUM_L4,
  parameter int PRE_BITS = PRETRG_BITS,
  parameter int DLY_BITS = DELAY_BITS
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [PRE_BITS*NUM_L4-1:0]   pretrigger_vector_i,
  input  logic [DLY_BITS*NUM_L4-1:0]   delay_vector_i,
  input  logic [NUM_L4-1:0]            l4_i,
  input  logic                         T1_mask_i,
  output logic [NUM_L4-1:0]            l4_matched_o,
  output logic                         T1_o,
  output logic                         T1_scaler_o,
  output logic [OFFSET_BITS-1:0]       T1_offset_o
);

  logic [NUM_L4-1:0]   tap_next;
  logic [NUM_L4-1:0]   qualify;
  logic                any_qualify;
  logic [PRE_BITS-1:0] sel_pre;

  for (genvar g = 0; g < NUM_L4; g++) begin : g_src
    trigger_handling_v2_delay_line #(
      .DELAY_BITS (DLY_BITS)
    ) u_delay (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .delay_i   (delay_vector_i[DLY_BITS*g +: DLY_BITS]),
      .l4_i      (l4_i[g]),
      .next_o    (tap_next[g]),
      .matched_o (l4_matched_o[g])
    );
  end

  // A source qualifies when its delayed bit is about to rise
  assign qualify     = tap_next & ~l4_matched_o;
  assign any_qualify = |qualify;

  // Lowest-index qualifying source selects the pretrigger (descending scan)
  always_comb begin
    sel_pre = '0;
    for (int i = NUM_L4 - 1; i >= 0; i--) begin
      if (qualify[i]) begin
        sel_pre = pretrigger_vector_i[PRE_BITS*i +: PRE_BITS];
      end
    end
  end

  // T1 pulses and offset update on the same edge as the matched rise
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      T1_o        <= 1'b0;
      T1_scaler_o <= 1'b0;
      T1_offset_o <= '0;
    end else begin
      T1_scaler_o <= any_qualify;
      T1_o        <= any_qualify & ~T1_mask_i;
      if (any_qualify) begin
        T1_offset_o <= calc_offset(OFFSET_BITS'(sel_pre));
      end
    end
  end

endmodule

// File: tb/tb_trigger_handling_v2.sv
// Directed bench for trigger_handling_v2: table of single-shot scenarios
// plus hand sequences for overlapping levels and reset corner cases.
module tb_trigger_handling_v2;
  import trigger_handling_v2_pkg::*;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] pretrigger_vector_i;
  logic [15:0] delay_vector_i;
  logic [3:0]  l4_i;
  logic        T1_mask_i;
  logic [3:0]  l4_matched_o;
  logic        T1_o;
  logic        T1_scaler_o;
  logic [8:0]  T1_offset_o;

  always #5 clk = ~clk;

  trigger_handling_v2 dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .pretrigger_vector_i (pretrigger_vector_i),
    .delay_vector_i      (delay_vector_i),
    .l4_i                (l4_i),
    .T1_mask_i           (T1_mask_i),
    .l4_matched_o        (l4_matched_o),
    .T1_o                (T1_o),
    .T1_scaler_o         (T1_scaler_o),
    .T1_offset_o         (T1_offset_o)
  );

  // Scoreboard state
  int         tests = 0;
  int         fails = 0;
  int         edge_n = 0;
  int         bc_base = 0;
  int         t1_cnt, sc_cnt, first_sc;
  int         rise_edge [4];
  logic [8:0] off_at_rise [4];
  int         high_cnt [4];
  logic [3:0] rise_mask, prev_m;

  typedef struct {
    logic [15:0] dly;
    logic [15:0] pre;
    logic [3:0]  pat;
    int          width;
    logic        mask;
    int          lat;
    int          off;
    int          t1;
    int          sc;
    int          src;
    int          bc_at_n;
  } vec_t;

  vec_t vecs [6];

  function automatic int bc_at(int e);
    return (bc_base + e / 2) & 511;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    t1_cnt = 0; sc_cnt = 0; first_sc = -1; rise_mask = '0;
    for (int i = 0; i < 4; i++) begin
      rise_edge[i] = -1; off_at_rise[i] = '0; high_cnt[i] = 0;
    end
    prev_m = l4_matched_o;
  endtask

  task automatic observe();
    if (T1_o) t1_cnt++;
    if (T1_scaler_o) begin
      sc_cnt++;
      if (first_sc < 0) first_sc = edge_n;
    end
    for (int i = 0; i < 4; i++) begin
      if (l4_matched_o[i]) high_cnt[i]++;
      if (l4_matched_o[i] && !prev_m[i]) begin
        rise_mask[i] = 1'b1;
        if (rise_edge[i] < 0) begin
          rise_edge[i] = edge_n;
          off_at_rise[i] = T1_offset_o;
        end
      end
    end
    prev_m = l4_matched_o;
  endtask

  // Driver: advance one clock, sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
    observe();
  endtask

  task automatic do_reset();
    rst_i = 1'b1; l4_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    clear_stats();
  endtask

  // Block-counter invariant for source s whose l4 rose at edge n
  task automatic check_inv(input string name, input int s, input int n, input logic [15:0] dly, input logic [15:0] pre);
    int lhs, rhs;
    lhs = (bc_at(rise_edge[s]) - int'(off_at_rise[s])) & 511;
    rhs = (bc_at(n) - BASE_OFFSET - int'(pre[4*s +: 4]) + int'(dly[4*s +: 4])) & 511;
    check(name, lhs, rhs);
  endtask

  initial begin
    int n;
    vec_t v;

    rst_i = 1'b1; l4_i = '0; T1_mask_i = 1'b0;
    pretrigger_vector_i = '0; delay_vector_i = '0;

    //            dly       pre       pat    w  mask lat off t1 sc src bc@N
    vecs[0] = '{16'h0003, 16'h0002, 4'b0001, 1, 1'b0, 8, 11, 1, 1, 0, 0};
    vecs[1] = '{16'h0003, 16'h0002, 4'b0001, 1, 1'b1, 8, 11, 0, 1, 0, 0};
    vecs[2] = '{16'h2020, 16'h0050, 4'b1010, 1, 1'b0, 6, 14, 1, 1, 1, 0};
    vecs[3] = '{16'h000F, 16'h000F, 4'b0001, 1, 1'b0, 32, 24, 1, 1, 0, 0};
    vecs[4] = '{16'h000F, 16'h000F, 4'b0001, 1, 1'b0, 32, 24, 1, 1, 0, 505};
    vecs[5] = '{16'h0000, 16'h0000, 4'b1000, 4, 1'b0, 2, 9, 1, 1, 3, 0};

    // Reset state
    do_reset();
    check("rst_matched", int'(l4_matched_o), 0);
    check("rst_t1", int'(T1_o), 0);
    check("rst_scaler", int'(T1_scaler_o), 0);
    check("rst_offset", int'(T1_offset_o), 0);

    // Table-driven single-shot scenarios
    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      delay_vector_i = v.dly; pretrigger_vector_i = v.pre; T1_mask_i = v.mask;
      do_reset();
      n = edge_n + 1;
      bc_base = v.bc_at_n - n / 2;
      for (int t = 0; t < 40; t++) begin
        l4_i = (t < v.width) ? v.pat : 4'b0000;
        tick();
      end
      check($sformatf("v%0d_t1_count", k), t1_cnt, v.t1);
      check($sformatf("v%0d_scaler_count", k), sc_cnt, v.sc);
      check($sformatf("v%0d_latency", k), first_sc - n, v.lat);
      check($sformatf("v%0d_offset", k), int'(T1_offset_o), v.off);
      check($sformatf("v%0d_rise_mask", k), int'(rise_mask), int'(v.pat));
      check($sformatf("v%0d_rise_latency", k), rise_edge[v.src] - n, v.lat);
      check($sformatf("v%0d_high_width", k), high_cnt[v.src], v.width);
      check_inv($sformatf("v%0d_invariant", k), v.src, n, v.dly, v.pre);
    end
    T1_mask_i = 1'b0;
    bc_base = 0;

    // Two sources, different delays, overlapping levels
    delay_vector_i = 16'h0003; pretrigger_vector_i = 16'h0102;
    do_reset();
    n = edge_n + 1;
    for (int t = 0; t < 56; t++) begin
      l4_i = (t < 3) ? 4'b0101 : (t < 36) ? 4'b0001 : 4'b0000;
      tick();
    end
    check("two_src2_latency", rise_edge[2] - n, 2);
    check("two_src2_offset", int'(off_at_rise[2]), 10);
    check("two_src0_latency", rise_edge[0] - n, 8);
    check("two_src0_offset", int'(off_at_rise[0]), 11);
    check("two_src0_width", high_cnt[0], 36);
    check("two_src2_width", high_cnt[2], 3);
    check("two_t1_count", t1_cnt, 2);
    check_inv("two_src0_invariant", 0, n, 16'h0003, 16'h0102);
    check_inv("two_src2_invariant", 2, n, 16'h0003, 16'h0102);

    // Reset one cycle before the delayed trigger would emerge
    delay_vector_i = 16'h0003; pretrigger_vector_i = 16'h0002;
    do_reset();
    l4_i = 4'b0001;
    tick();
    l4_i = 4'b0000;
    for (int t = 0; t < 6; t++) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst_matched", int'(l4_matched_o), 0);
    check("midrst_t1", int'(T1_o), 0);
    check("midrst_scaler", int'(T1_scaler_o), 0);
    check("midrst_offset", int'(T1_offset_o), 0);
    clear_stats();
    for (int t = 0; t < 40; t++) tick();
    check("midrst_no_t1", t1_cnt, 0);
    check("midrst_no_scaler", sc_cnt, 0);
    check("midrst_no_rise", int'(rise_mask), 0);

    // Level already high when reset releases counts as a rise
    delay_vector_i = 16'h0000; pretrigger_vector_i = 16'h0000;
    rst_i = 1'b1; l4_i = 4'b0001;
    tick(); tick();
    rst_i = 1'b0;
    clear_stats();
    n = edge_n + 1;
    for (int t = 0; t < 10; t++) tick();
    l4_i = 4'b0000;
    for (int t = 0; t < 5; t++) tick();
    check("relhigh_latency", rise_edge[0] - n, 2);
    check("relhigh_t1_count", t1_cnt, 1);
    check("relhigh_offset", int'(T1_offset_o), 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
